// File: rtl/nibble_demux_pkg.sv
// Shared types and default geometry for the nibble demultiplexer.
// Mode encoding matches the board switch: 0 = fixed select, 1 = round-robin.
package nibble_demux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_SEL_W  = 2;

endpackage

// File: rtl/nibble_demux_if.sv
// Bundle of the input stream, channel outputs and per-channel acks of nibble_demux.
// master = the producer/consumer side (bench or board), slave = the demux itself.
interface nibble_demux_if
    import nibble_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int SEL_W  = DEF_SEL_W
);

    // Handshake: a word moves on a rising edge where in_valid & in_ready are both 1.
    // in_ready never looks at in_valid; out_valid[k] holds until out_ack[k] is seen at an edge.
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ack;
    logic [SEL_W-1:0]       cur_ch;

    modport master (
        output mode, sel, in_data, in_valid, out_ack,
        input  in_ready, out_data, out_valid, cur_ch
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ack,
        output in_ready, out_data, out_valid, cur_ch
    );

endinterface

// File: rtl/nibble_demux_slot.sv
// One output slot: a data register plus a valid flag.
// A load in the same cycle as an ack wins, which gives a 1 word/cycle pass-through.
module nibble_demux_slot
    import nibble_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ack,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (ack) begin
            // Data is kept after consumption; only the flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/nibble_demux.sv
// Registered 1-to-N demultiplexer: steers each accepted word into one of N_CH slots,
// chosen by a fixed select or a strict in-order round-robin pointer.
module nibble_demux
    import nibble_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic           clk,
    input  logic           rst,
    nibble_demux_if.slave  bus
);

    // One extra bit so that N_CH itself is representable when comparing against target.
    localparam logic [SEL_W:0]   N_CH_W  = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0]       rr_ptr_q;
    logic [SEL_W-1:0]       rr_ptr_d;
    logic [SEL_W-1:0]       target;
    logic                   rr_mode;
    logic                   target_ok;
    logic                   tgt_valid;
    logic                   tgt_ack;
    logic                   in_ready;
    logic                   accept;
    logic [N_CH-1:0]        load;
    logic [N_CH-1:0]        slot_valid;
    logic [N_CH*DATA_W-1:0] slot_data;

    assign rr_mode = (mode_e'(bus.mode) == MODE_RR);
    assign target  = rr_mode ? rr_ptr_q : bus.sel;

    // Status of the targeted slot; an out-of-range select matches no slot.
    always_comb begin
        target_ok = ({1'b0, target} < N_CH_W);
        tgt_valid = 1'b0;
        tgt_ack   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (target == SEL_W'(k)) begin
                tgt_valid = slot_valid[k];
                tgt_ack   = bus.out_ack[k];
            end
        end
    end

    assign in_ready = target_ok & (~tgt_valid | tgt_ack);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = accept & (target == SEL_W'(k));
        end
    end

    // The pointer only advances on round-robin transfers, so a full next slot stalls the stream.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && rr_mode) begin
            rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        nibble_demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .ack   (bus.out_ack[k]),
            .d     (bus.in_data),
            .q     (slot_data[k*DATA_W +: DATA_W]),
            .valid (slot_valid[k])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.cur_ch    = target;
    assign bus.out_data  = slot_data;
    assign bus.out_valid = slot_valid;

endmodule

// File: tb/tb_nibble_demux.sv
// Bench for nibble_demux: a 4-channel build driven from a vector table and a stall sequence,
// plus a 3-channel build for out-of-range select and mid-stream reset.
module tb_nibble_demux;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    // Scoreboard entries: {channel[1:0], data[3:0]} pushed on an expected transfer.
    logic [5:0] exp_q[$];

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] data;
        logic       valid;
        logic [3:0] ack;
        logic       exp_ready;
        logic [1:0] exp_ch;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vecs[23];

    nibble_demux_if #(.DATA_W(4), .N_CH(4), .SEL_W(2)) u_if4 ();
    nibble_demux_if #(.DATA_W(4), .N_CH(3), .SEL_W(2)) u_if3 ();

    nibble_demux #(.DATA_W(4), .N_CH(4), .SEL_W(2)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4)
    );

    nibble_demux #(.DATA_W(4), .N_CH(3), .SEL_W(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (u_if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector on the 4-channel DUT, check handshake mid-cycle, then the registered result.
    task automatic apply4(input vec_t v, input string name);
        logic       pushed;
        logic [5:0] e;
        int         ch;
        u_if4.mode     = v.mode;
        u_if4.sel      = v.sel;
        u_if4.in_data  = v.data;
        u_if4.in_valid = v.valid;
        u_if4.out_ack  = v.ack;
        #3;
        chk({name, " in_ready"}, 32'(u_if4.in_ready), 32'(v.exp_ready));
        chk({name, " cur_ch"}, 32'(u_if4.cur_ch), 32'(v.exp_ch));
        pushed = v.valid & v.exp_ready;
        if (pushed) exp_q.push_back({v.exp_ch, v.data});
        next_edge();
        chk({name, " out_valid"}, 32'(u_if4.out_valid), 32'(v.exp_ov));
        if (pushed) begin
            e  = exp_q.pop_front();
            ch = int'(e[5:4]);
            chk({name, " slot data"}, 32'(u_if4.out_data[ch*4 +: 4]), 32'(e[3:0]));
        end
    endtask

    task automatic apply3(input string name, input logic mode, input logic [1:0] sel,
                          input logic [3:0] data, input logic valid, input logic [2:0] ack,
                          input logic exp_ready, input logic [1:0] exp_ch,
                          input logic [2:0] exp_ov, input logic [11:0] exp_od);
        u_if3.mode     = mode;
        u_if3.sel      = sel;
        u_if3.in_data  = data;
        u_if3.in_valid = valid;
        u_if3.out_ack  = ack;
        #3;
        chk({name, " in_ready"}, 32'(u_if3.in_ready), 32'(exp_ready));
        chk({name, " cur_ch"}, 32'(u_if3.cur_ch), 32'(exp_ch));
        next_edge();
        chk({name, " out_valid"}, 32'(u_if3.out_valid), 32'(exp_ov));
        chk({name, " out_data"}, 32'(u_if3.out_data), 32'(exp_od));
    endtask

    initial begin
        vec_t stall_v;
        n_total = 0;
        n_pass  = 0;

        //            mode  sel   data   vld   ack      rdy   ch    out_valid
        vecs[0]  = '{1'b0, 2'd2, 4'hA, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0100};
        vecs[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0100};
        vecs[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0100};
        vecs[3]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100};
        vecs[4]  = '{1'b0, 2'd2, 4'h0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000};
        vecs[5]  = '{1'b1, 2'd0, 4'hC, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0001};
        vecs[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd1, 4'b0010};
        vecs[7]  = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0010, 1'b1, 2'd2, 4'b0100};
        vecs[8]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0100, 1'b1, 2'd3, 4'b1000};
        vecs[9]  = '{1'b1, 2'd0, 4'hE, 1'b1, 4'b1000, 1'b1, 2'd0, 4'b0001};
        vecs[10] = '{1'b1, 2'd0, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0001};
        vecs[11] = '{1'b0, 2'd1, 4'h3, 1'b1, 4'b0001, 1'b1, 2'd1, 4'b0010};
        vecs[12] = '{1'b0, 2'd1, 4'h5, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010};
        vecs[13] = '{1'b0, 2'd1, 4'h6, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010};
        vecs[14] = '{1'b0, 2'd1, 4'h0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000};
        vecs[15] = '{1'b1, 2'd0, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0000};
        vecs[16] = '{1'b1, 2'd0, 4'h1, 1'b1, 4'b0000, 1'b1, 2'd1, 4'b0010};
        vecs[17] = '{1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd2, 4'b0100};
        vecs[18] = '{1'b1, 2'd0, 4'h7, 1'b1, 4'b0100, 1'b1, 2'd3, 4'b1000};
        vecs[19] = '{1'b1, 2'd0, 4'h8, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b1001};
        vecs[20] = '{1'b1, 2'd0, 4'h9, 1'b1, 4'b0001, 1'b1, 2'd1, 4'b1010};
        vecs[21] = '{1'b1, 2'd0, 4'hB, 1'b1, 4'b0010, 1'b1, 2'd2, 4'b1100};
        vecs[22] = '{1'b1, 2'd0, 4'hC, 1'b1, 4'b0100, 1'b0, 2'd3, 4'b1000};

        // Reset for two edges with a word offered on both DUTs: nothing may load.
        rst            = 1'b1;
        u_if4.mode     = 1'b0;
        u_if4.sel      = 2'd1;
        u_if4.in_data  = 4'hF;
        u_if4.in_valid = 1'b1;
        u_if4.out_ack  = 4'b0000;
        u_if3.mode     = 1'b0;
        u_if3.sel      = 2'd1;
        u_if3.in_data  = 4'hF;
        u_if3.in_valid = 1'b1;
        u_if3.out_ack  = 3'b000;
        next_edge();
        next_edge();
        rst            = 1'b0;
        u_if4.in_valid = 1'b0;
        u_if4.mode     = 1'b1;
        u_if3.in_valid = 1'b0;
        u_if3.mode     = 1'b0;
        u_if3.sel      = 2'd0;
        #1;
        chk("reset out_valid", 32'(u_if4.out_valid), 32'h0);
        chk("reset out_data", 32'(u_if4.out_data), 32'h0);
        chk("reset cur_ch rr", 32'(u_if4.cur_ch), 32'h0);
        chk("reset out_valid n3", 32'(u_if3.out_valid), 32'h0);
        chk("reset out_data n3", 32'(u_if3.out_data), 32'h0);
        next_edge();

        for (int i = 0; i < 23; i++) begin
            apply4(vecs[i], $sformatf("vec%0d", i));
        end

        // Round-robin stall on a full slot 3: pointer and data must hold.
        stall_v = '{1'b1, 2'd0, 4'hC, 1'b1, 4'b0000, 1'b0, 2'd3, 4'b1000};
        for (int i = 0; i < 10; i++) begin
            apply4(stall_v, $sformatf("stall%0d", i));
        end
        chk("stall slot3 held", 32'(u_if4.out_data[15:12]), 32'h7);
        apply4('{1'b1, 2'd0, 4'hC, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000}, "stall release");
        apply4('{1'b1, 2'd0, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b1000}, "rr wrapped");
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        u_if4.out_ack = 4'b0000;

        // 3-channel build: out-of-range select, then reset in the middle of a round-robin stream.
        apply3("n3 load ch0",   1'b0, 2'd0, 4'h4, 1'b1, 3'b000, 1'b1, 2'd0, 3'b001, 12'h004);
        apply3("n3 sel3",       1'b0, 2'd3, 4'h5, 1'b1, 3'b000, 1'b0, 2'd3, 3'b001, 12'h004);
        apply3("n3 rr ch0",     1'b1, 2'd0, 4'h6, 1'b1, 3'b001, 1'b1, 2'd0, 3'b001, 12'h006);
        apply3("n3 rr ch1",     1'b1, 2'd0, 4'h7, 1'b1, 3'b001, 1'b1, 2'd1, 3'b010, 12'h076);
        apply3("n3 rr at ch2",  1'b1, 2'd0, 4'h0, 1'b0, 3'b000, 1'b1, 2'd2, 3'b010, 12'h076);

        rst            = 1'b1;
        u_if3.in_data  = 4'h9;
        u_if3.in_valid = 1'b1;
        next_edge();
        chk("n3 midreset out_valid", 32'(u_if3.out_valid), 32'h0);
        chk("n3 midreset out_data", 32'(u_if3.out_data), 32'h0);
        chk("n3 midreset rr_ptr", 32'(u_if3.cur_ch), 32'h0);
        chk("midreset out_valid n4", 32'(u_if4.out_valid), 32'h0);
        rst            = 1'b0;
        u_if3.in_valid = 1'b0;
        next_edge();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
